// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master engine.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      ADDR     = 3'd2,
      ADDR_ACK = 3'd3,
      DATA     = 3'd4,
      DATA_ACK = 3'd5,
      STOP     = 3'd6
   } i2c_state_e;

   // status_reg bit positions
   localparam int ST_NACK = 7;
   localparam int ST_BUSY = 6;
   localparam int ST_RXE  = 5;
   localparam int ST_TXF  = 4;
   localparam int ST_DONE = 0;

   // command_reg bit positions
   localparam int CMD_ABORT = 7;
   localparam int CMD_GO    = 0;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-bit prescaler: counts 0..prescale while enabled and pulses tick on
// the terminal count. Held at zero while disabled so every transaction starts
// from a fresh quarter.
module i2c_clk_div (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       en,
   input  logic [7:0] prescale,
   output logic       tick
);

   logic [7:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == prescale);

   // next count: clear when disabled or at terminal count
   always_comb begin
      cnt_d = cnt_q;
      if (!en)
         cnt_d = 8'd0;
      else if (cnt_q == prescale)
         cnt_d = 8'd0;
      else
         cnt_d = cnt_q + 8'd1;
   end

   // count register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2c_master_core.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK,
// STOP. Every bit slot is four quarters; SCL/SDA are open-drain enables.
//
// Host handshake: tx_wr and rx_rd are single-cycle strobes with no
// back-pressure. tx_wr is accepted only while tx_full=0 (otherwise dropped);
// rx_rd unconditionally marks the receive byte consumed. tx_full/rx_empty
// in status_reg are the flow-control flags the host must observe.
module i2c_master_core
   import i2c_pkg::*;
(
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic [7:0] command_reg,
   input  logic [7:0] prescale_reg,
   input  logic [7:0] address_reg,
   input  logic [7:0] transmit_reg,
   input  logic       tx_wr,
   input  logic       rx_rd,
   input  logic       sda_i,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic [7:0] status_reg,
   output logic [7:0] receive_reg
);

   i2c_state_e state_q, state_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] presc_q, presc_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic       is_wr_q, is_wr_d;
   logic       samp_q, samp_d;
   logic       tx_full_q, tx_full_d;
   logic       rx_empty_q, rx_empty_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       nack_q, nack_d;
   logic       scl_oe_q, scl_oe_d;
   logic       sda_oe_q, sda_oe_d;
   logic       tick, slot_end;
   logic       unused_cmd;

   assign unused_cmd = ^command_reg[6:1];

   i2c_clk_div u_clk_div (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .en       (state_q != IDLE),
      .prescale (presc_q),
      .tick     (tick)
   );

   assign slot_end = tick && (qtr_q == 2'd3);

   // next-state, datapath and flag updates
   always_comb begin
      state_d    = state_q;
      qtr_d      = qtr_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      presc_d    = presc_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      is_wr_d    = is_wr_q;
      samp_d     = samp_q;
      tx_full_d  = tx_full_q;
      rx_empty_d = rx_empty_q;
      busy_d     = busy_q;
      done_d     = done_q;
      nack_d     = nack_q;

      if (tx_wr && !tx_full_q) begin
         tx_d      = transmit_reg;
         tx_full_d = 1'b1;
      end
      if (rx_rd)
         rx_empty_d = 1'b1;

      if (tick)
         qtr_d = qtr_q + 2'd1;
      // SDA is sampled while SCL has been high for a full quarter
      if (tick && (qtr_q == 2'd2))
         samp_d = sda_i;

      if (command_reg[CMD_ABORT]) begin
         state_d = IDLE;
         qtr_d   = 2'd0;
         bit_d   = 3'd0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (command_reg[CMD_GO] && (address_reg[0] ? tx_full_q : rx_empty_q)) begin
                  state_d = START;
                  qtr_d   = 2'd0;
                  bit_d   = 3'd0;
                  is_wr_d = address_reg[0];
                  presc_d = prescale_reg;
                  shift_d = {address_reg[7:1], ~address_reg[0]};
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  nack_d  = 1'b0;
               end
            end
            START: begin
               if (slot_end)
                  state_d = ADDR;
            end
            ADDR: begin
               if (slot_end) begin
                  shift_d = {shift_q[6:0], samp_q};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7)
                     state_d = ADDR_ACK;
               end
            end
            ADDR_ACK: begin
               if (slot_end) begin
                  if (samp_q) begin
                     nack_d  = 1'b1;
                     state_d = STOP;
                  end else begin
                     state_d = DATA;
                     shift_d = is_wr_q ? tx_q : 8'h00;
                  end
               end
            end
            DATA: begin
               if (slot_end) begin
                  shift_d = {shift_q[6:0], samp_q};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7)
                     state_d = DATA_ACK;
               end
            end
            DATA_ACK: begin
               if (slot_end) begin
                  state_d = STOP;
                  if (is_wr_q) begin
                     if (samp_q)
                        nack_d = 1'b1;
                     tx_full_d = 1'b0;
                  end else begin
                     rx_d       = shift_q;
                     rx_empty_d = 1'b0;
                  end
               end
            end
            STOP: begin
               if (slot_end) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // line drive decoded from the upcoming state/quarter so outputs are registered
   always_comb begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_d)
         START:    sda_oe_d = qtr_d[1];
         ADDR: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = ~shift_d[7];
         end
         ADDR_ACK: scl_oe_d = ~qtr_d[1];
         DATA: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = is_wr_q & ~shift_d[7];
         end
         DATA_ACK: scl_oe_d = ~qtr_d[1];
         STOP: begin
            scl_oe_d = (qtr_d == 2'd0);
            sda_oe_d = ~qtr_d[1];
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         qtr_q      <= 2'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         presc_q    <= 8'h00;
         tx_q       <= 8'h00;
         rx_q       <= 8'h00;
         is_wr_q    <= 1'b0;
         samp_q     <= 1'b0;
         tx_full_q  <= 1'b0;
         rx_empty_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         qtr_q      <= qtr_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         presc_q    <= presc_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         is_wr_q    <= is_wr_d;
         samp_q     <= samp_d;
         tx_full_q  <= tx_full_d;
         rx_empty_q <= rx_empty_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         nack_q     <= nack_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   // status word assembly
   always_comb begin
      status_reg          = 8'h00;
      status_reg[ST_NACK] = nack_q;
      status_reg[ST_BUSY] = busy_q;
      status_reg[ST_RXE]  = rx_empty_q;
      status_reg[ST_TXF]  = tx_full_q;
      status_reg[ST_DONE] = done_q;
   end

   assign scl_oe      = scl_oe_q;
   assign sda_oe      = sda_oe_q;
   assign receive_reg = rx_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: open-drain bus with a behavioural slave, a wire
// monitor, and a scoreboard of expected values.
module tb_i2c_master_core;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic [7:0] command_reg, prescale_reg, address_reg, transmit_reg;
   logic       tx_wr, rx_rd;
   logic       sda_i;
   logic       scl_oe, sda_oe;
   logic [7:0] status_reg, receive_reg;

   i2c_master_core dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .command_reg  (command_reg),
      .prescale_reg (prescale_reg),
      .address_reg  (address_reg),
      .transmit_reg (transmit_reg),
      .tx_wr        (tx_wr),
      .rx_rd        (rx_rd),
      .sda_i        (sda_i),
      .scl_oe       (scl_oe),
      .sda_oe       (sda_oe),
      .status_reg   (status_reg),
      .receive_reg  (receive_reg)
   );

   // clock
   always #5 PCLK = ~PCLK;

   // slave behaviour knobs
   logic       ack_addr, ack_data, sl_rd;
   logic [7:0] sl_byte;

   // bus and monitor state
   logic slave_pull = 1'b0;
   logic scl_prev = 1'b0, sda_prev = 1'b0;
   int   cyc = 0, fall_cnt = 0, rise_cnt = 0;
   logic rise_bits [0:31];
   int   rise_cyc  [0:31];

   assign sda_i = ~(sda_oe | slave_pull);

   function automatic logic slave_drive(input int slot);
      logic [2:0] idx;
      idx = 3'(16 - slot);
      if (slot == 8) return ack_addr;
      if (slot >= 9 && slot <= 16) return sl_rd & ~sl_byte[idx];
      if (slot == 17) return ~sl_rd & ack_data;
      return 1'b0;
   endfunction

   // wire monitor and slave: START resets slot counters, SCL falls set the
   // slave drive for the coming slot, SCL rises record the line value
   always @(negedge PCLK) begin
      cyc++;
      if (!PRESETn) begin
         slave_pull = 1'b0;
         scl_prev   = 1'b0;
         sda_prev   = 1'b0;
      end else begin
         if (!scl_oe && !scl_prev && !sda_prev && sda_oe) begin
            fall_cnt   = 0;
            rise_cnt   = 0;
            slave_pull = 1'b0;
         end else if (scl_oe && !scl_prev) begin
            slave_pull = slave_drive(fall_cnt);
            fall_cnt++;
         end else if (!scl_oe && scl_prev) begin
            if (rise_cnt < 32) begin
               rise_bits[rise_cnt] = sda_i;
               rise_cyc[rise_cnt]  = cyc;
            end
            rise_cnt++;
         end
         scl_prev = scl_oe;
         sda_prev = sda_oe;
      end
   end

   // scoreboard
   int          n_tests = 0, n_fail = 0;
   logic [15:0] exp_q[$];

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [15:0] got);
      logic [15:0] e;
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check_val(tag, got, e);
   endtask

   function automatic logic [7:0] wire_byte(input int base);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = rise_bits[base+i];
      return b;
   endfunction

   // driver tasks
   task automatic tick_n(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic do_tx_wr(input logic [7:0] b);
      transmit_reg = b;
      tx_wr = 1'b1;
      @(negedge PCLK);
      tx_wr = 1'b0;
   endtask

   task automatic do_rx_rd();
      rx_rd = 1'b1;
      @(negedge PCLK);
      rx_rd = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int busy_cyc);
      logic timed_out;
      timed_out = 1'b1;
      busy_cyc  = 0;
      for (int t = 0; t < 4000; t++) begin
         @(negedge PCLK);
         if (status_reg[6]) busy_cyc++;
         if (status_reg[0] && !status_reg[6]) begin
            timed_out = 1'b0;
            break;
         end
      end
      check_val({tag, "_timeout"}, 16'(timed_out), 16'd0);
   endtask

   task automatic wait_fall(input string tag, input int n);
      logic timed_out;
      timed_out = 1'b1;
      for (int t = 0; t < 2000; t++) begin
         @(negedge PCLK);
         if (fall_cnt == n) begin
            timed_out = 1'b0;
            break;
         end
      end
      check_val({tag, "_timeout"}, 16'(timed_out), 16'd0);
   endtask

   int busy;

   // stimulus
   initial begin
      PRESETn = 1'b0; command_reg = 8'h00; prescale_reg = 8'd4; address_reg = 8'h00;
      transmit_reg = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0;
      ack_addr = 1'b1; ack_data = 1'b1; sl_rd = 1'b0; sl_byte = 8'h00;
      tick_n(3);
      PRESETn = 1'b1;
      tick_n(1);

      // reset state
      exp_q.push_back(16'h20); sb_check("rst_status", status_reg);
      exp_q.push_back(16'h00); sb_check("rst_rx", receive_reg);
      exp_q.push_back(16'h0);  sb_check("rst_lines", {scl_oe, sda_oe});

      // go gating: write with empty tx holding register must wait
      address_reg = 8'hA1; command_reg = 8'h01;
      tick_n(40);
      exp_q.push_back(16'h20); sb_check("gate_idle_status", status_reg);
      exp_q.push_back(16'h0);  sb_check("gate_idle_lines", {scl_oe, sda_oe});
      exp_q.push_back(16'hA0); exp_q.push_back(16'h96);
      exp_q.push_back(16'h21); exp_q.push_back(16'd400);
      do_tx_wr(8'h96);
      wait_done("gate", busy);
      command_reg = 8'h00;
      sb_check("gate_addr", wire_byte(0));
      sb_check("gate_data", wire_byte(9));
      sb_check("gate_status", status_reg);
      sb_check("gate_busy", 16'(busy));

      // ACKed write; second tx_wr while full is dropped
      do_tx_wr(8'h5A);
      exp_q.push_back(16'h31); sb_check("wr_txfull", status_reg);
      do_tx_wr(8'h77);
      exp_q.push_back(16'hA0); exp_q.push_back(16'h5A); exp_q.push_back(16'h0);
      exp_q.push_back(16'h21); exp_q.push_back(16'd400); exp_q.push_back(16'd19);
      command_reg = 8'h01;
      wait_done("wr", busy);
      command_reg = 8'h00;
      sb_check("wr_addr", wire_byte(0));
      sb_check("wr_data", wire_byte(9));
      sb_check("wr_acks", {rise_bits[8], rise_bits[17]});
      sb_check("wr_status", status_reg);
      sb_check("wr_busy", 16'(busy));
      sb_check("wr_rises", 16'(rise_cnt));

      // ACKed read; master NACKs the byte
      address_reg = 8'hA0; sl_rd = 1'b1; sl_byte = 8'hC3;
      exp_q.push_back(16'hA1); exp_q.push_back(16'h1);
      exp_q.push_back(16'hC3); exp_q.push_back(16'h01); exp_q.push_back(16'h21);
      command_reg = 8'h01;
      wait_done("rd", busy);
      command_reg = 8'h00;
      sb_check("rd_addr", wire_byte(0));
      sb_check("rd_master_nack", 16'(rise_bits[17]));
      sb_check("rd_data", receive_reg);
      sb_check("rd_status", status_reg);
      do_rx_rd();
      sb_check("rd_after_rx_rd", status_reg);

      // address NACK: straight to STOP, tx byte kept
      sl_rd = 1'b0; ack_addr = 1'b0; address_reg = 8'hA1;
      do_tx_wr(8'h3C);
      exp_q.push_back(16'hA0); exp_q.push_back(16'hB1);
      exp_q.push_back(16'd10); exp_q.push_back(16'd220);
      command_reg = 8'h01;
      wait_done("nack", busy);
      command_reg = 8'h00;
      sb_check("nack_addr", wire_byte(0));
      sb_check("nack_status", status_reg);
      sb_check("nack_rises", 16'(rise_cnt));
      sb_check("nack_busy", 16'(busy));

      // soft abort during address bit 3
      ack_addr = 1'b1;
      command_reg = 8'h01;
      wait_fall("abort_wait", 4);
      tick_n(2);
      command_reg = 8'h81;
      tick_n(1);
      exp_q.push_back(16'h0);  sb_check("abort_lines", {scl_oe, sda_oe});
      exp_q.push_back(16'h30); sb_check("abort_status", status_reg);
      command_reg = 8'h00;
      tick_n(10);
      exp_q.push_back(16'h0);  sb_check("abort_lines_hold", {scl_oe, sda_oe});

      // asynchronous reset during the data byte
      command_reg = 8'h01;
      wait_fall("rst_wait", 12);
      tick_n(1);
      PRESETn = 1'b0;
      #1;
      exp_q.push_back(16'h20); sb_check("midrst_status", status_reg);
      exp_q.push_back(16'h0);  sb_check("midrst_lines", {scl_oe, sda_oe});
      exp_q.push_back(16'h00); sb_check("midrst_rx", receive_reg);
      command_reg = 8'h00;
      tick_n(2);
      PRESETn = 1'b1;
      tick_n(2);

      // prescale 0: one quarter per PCLK
      prescale_reg = 8'd0; address_reg = 8'hA1;
      do_tx_wr(8'h81);
      exp_q.push_back(16'h81); exp_q.push_back(16'd4);
      exp_q.push_back(16'd80); exp_q.push_back(16'h21);
      command_reg = 8'h01;
      wait_done("p0", busy);
      command_reg = 8'h00;
      sb_check("p0_data", wire_byte(9));
      sb_check("p0_scl_period", 16'(rise_cyc[2] - rise_cyc[1]));
      sb_check("p0_busy", 16'(busy));
      sb_check("p0_status", status_reg);

      // report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
